// File: rtl/altpcierd_rx_st_adapter.sv
// altpcierd_rx_st_adapter
//   RX Avalon-ST adapter between the PCIe hard-IP RX stream and the DMA
//   application. The HIP keeps sending for READY_LATENCY cycles after it sees
//   ready drop. A first-word-fall-through FIFO absorbs those beats. The app
//   side gets a ready-latency-0 valid/ready handshake.
//
//   Beat packing on app_rx_data: {[err,] be, sop, eop, bardec, data}
//
//   Optional feature macro: ALTPCIERD_RX_ERR_FLAG_EN
//     defined   : hip_rx_err is stored as the MSB of each beat (PW += 1)
//     undefined : hip_rx_err is ignored; the 64-bit packing is the legacy 82 bits
//
// Ports
//   clk_in, rstn                 app clock, async active-low reset
//   hip_rx_*  (in)               HIP beat: valid/data/be/sop/eop/bardec/err
//   hip_rx_ready (out)           registered ready back to the HIP
//   hip_rx_mask  (out)           app_rx_mask delayed by one cycle
//   app_rx_mask  (in)            app request to hold non-posted TLPs
//   app_rx_data/valid (out)      FIFO head and not-empty flag
//   app_rx_ready (in)            pops the head when valid
//   fifo_level (out)             occupancy, 0..FIFO_DEPTH
//   overflow, framing_err (out)  sticky error flags, cleared only by rstn
module altpcierd_rx_st_adapter #(
  parameter int DATA_WIDTH    = 64,
  parameter int READY_LATENCY = 2,
  parameter int FIFO_DEPTH    = 8,
`ifdef ALTPCIERD_RX_ERR_FLAG_EN
  localparam int PW = DATA_WIDTH + DATA_WIDTH/8 + 11,
`else
  localparam int PW = DATA_WIDTH + DATA_WIDTH/8 + 10,
`endif
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                    clk_in,
  input  logic                    rstn,
  input  logic                    hip_rx_valid,
  input  logic [DATA_WIDTH-1:0]   hip_rx_data,
  input  logic [DATA_WIDTH/8-1:0] hip_rx_be,
  input  logic                    hip_rx_sop,
  input  logic                    hip_rx_eop,
  input  logic [7:0]              hip_rx_bardec,
  input  logic                    hip_rx_err,
  output logic                    hip_rx_ready,
  output logic                    hip_rx_mask,
  input  logic                    app_rx_mask,
  output logic [PW-1:0]           app_rx_data,
  output logic                    app_rx_valid,
  input  logic                    app_rx_ready,
  output logic [LW-1:0]           fifo_level,
  output logic                    overflow,
  output logic                    framing_err
);

  typedef enum logic {IDLE, PKT} frm_t;

  logic [PW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_nxt;
  logic          full, push, pop, push_ok;
  logic [PW-1:0] wr_beat;
  frm_t          frm;

`ifdef ALTPCIERD_RX_ERR_FLAG_EN
  assign wr_beat = {hip_rx_err, hip_rx_be, hip_rx_sop, hip_rx_eop, hip_rx_bardec, hip_rx_data};
`else
  logic unused_err;
  assign unused_err = hip_rx_err;
  assign wr_beat = {hip_rx_be, hip_rx_sop, hip_rx_eop, hip_rx_bardec, hip_rx_data};
`endif

  // The HIP is not ready-qualified. Any valid beat is a push attempt,
  // because beats still arrive during the ready latency.
  assign push      = hip_rx_valid;
  assign full      = (level == LW'(FIFO_DEPTH));
  assign pop       = app_rx_valid & app_rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push & (~full | pop);
  assign level_nxt = level + LW'(push_ok) - LW'(pop);

  assign app_rx_valid = (level != '0);
  assign app_rx_data  = mem[rd_ptr];
  assign fifo_level   = level;

  // Storage has no reset. The head is don't-care while app_rx_valid is low.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= wr_beat;
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      hip_rx_ready <= 1'b0;
      hip_rx_mask  <= 1'b0;
      overflow     <= 1'b0;
      framing_err  <= 1'b0;
      frm          <= IDLE;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      // Keep READY_LATENCY+1 slots of headroom. The HIP may still send
      // READY_LATENCY beats after it sees ready drop.
      hip_rx_ready <= (level_nxt <= LW'(FIFO_DEPTH - READY_LATENCY - 1));
      hip_rx_mask  <= app_rx_mask;
      if (push & full & ~pop) overflow <= 1'b1;
      // Framing tracks accepted beats only. On an error the FSM still
      // resyncs to the beat's sop/eop so that a later packet can recover.
      if (push_ok) begin
        if ((frm == PKT && hip_rx_sop) || (frm == IDLE && !hip_rx_sop))
          framing_err <= 1'b1;
        if (hip_rx_eop)      frm <= IDLE;
        else if (hip_rx_sop) frm <= PKT;
      end
    end
  end

endmodule

// File: tb/tb_altpcierd_rx_st_adapter.sv
module tb_altpcierd_rx_st_adapter;
  localparam int DW = 64;
  localparam int RL = 2;
  localparam int D  = 8;
`ifdef ALTPCIERD_RX_ERR_FLAG_EN
  localparam int PW = DW + DW/8 + 11;
`else
  localparam int PW = DW + DW/8 + 10;
`endif
  localparam int LW = $clog2(D) + 1;

  logic            clk_in = 1'b0;
  logic            rstn;
  logic            hip_rx_valid, hip_rx_sop, hip_rx_eop, hip_rx_err;
  logic [DW-1:0]   hip_rx_data;
  logic [DW/8-1:0] hip_rx_be;
  logic [7:0]      hip_rx_bardec;
  logic            hip_rx_ready, hip_rx_mask, app_rx_mask;
  logic [PW-1:0]   app_rx_data;
  logic            app_rx_valid, app_rx_ready;
  logic [LW-1:0]   fifo_level;
  logic            overflow, framing_err;

  altpcierd_rx_st_adapter #(.DATA_WIDTH(DW), .READY_LATENCY(RL), .FIFO_DEPTH(D)) dut (
    .clk_in(clk_in), .rstn(rstn),
    .hip_rx_valid(hip_rx_valid), .hip_rx_data(hip_rx_data), .hip_rx_be(hip_rx_be),
    .hip_rx_sop(hip_rx_sop), .hip_rx_eop(hip_rx_eop), .hip_rx_bardec(hip_rx_bardec),
    .hip_rx_err(hip_rx_err), .hip_rx_ready(hip_rx_ready), .hip_rx_mask(hip_rx_mask),
    .app_rx_mask(app_rx_mask), .app_rx_data(app_rx_data), .app_rx_valid(app_rx_valid),
    .app_rx_ready(app_rx_ready), .fifo_level(fifo_level), .overflow(overflow),
    .framing_err(framing_err));

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of packed beats plus spec-level flags.
  logic [PW-1:0] q[$];
  bit m_ovf, m_ferr, m_inpkt, m_rdy, m_mask;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("valid", 128'(app_rx_valid), 128'(q.size() != 0));
    chk("level", 128'(fifo_level), 128'(q.size()));
    if (q.size() != 0) chk("data", 128'(app_rx_data), 128'(q[0]));
    chk("ready", 128'(hip_rx_ready), 128'(m_rdy));
    chk("mask", 128'(hip_rx_mask), 128'(m_mask));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("framing_err", 128'(framing_err), 128'(m_ferr));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_ferr = 0; m_inpkt = 0; m_rdy = 0; m_mask = 0;
  endtask

  // Called at a negedge: check outputs, drive one cycle of inputs, apply the
  // model for the coming posedge, then advance to the next negedge.
  task automatic step(input logic v, input logic s, input logic e, input logic r, input logic m);
    logic [PW-1:0] beat;
    bit pop, full;
    check_outs();
    hip_rx_valid  = v;
    hip_rx_sop    = s;
    hip_rx_eop    = e;
    hip_rx_data   = {$urandom, $urandom};
    hip_rx_be     = 8'($urandom);
    hip_rx_bardec = 8'($urandom);
    hip_rx_err    = 1'($urandom_range(0, 1));
    app_rx_ready  = r;
    app_rx_mask   = m;
`ifdef ALTPCIERD_RX_ERR_FLAG_EN
    beat = {hip_rx_err, hip_rx_be, hip_rx_sop, hip_rx_eop, hip_rx_bardec, hip_rx_data};
`else
    beat = {hip_rx_be, hip_rx_sop, hip_rx_eop, hip_rx_bardec, hip_rx_data};
`endif
    pop  = (q.size() != 0) && r;
    full = (q.size() == D);
    if (pop) void'(q.pop_front());
    if (v && full && !pop) m_ovf = 1;
    else if (v) begin
      q.push_back(beat);
      if (m_inpkt == s) m_ferr = 1;  // sop inside packet, or non-sop outside
      if (e) m_inpkt = 0;
      else if (s) m_inpkt = 1;
    end
    m_rdy  = (q.size() <= D - RL - 1);
    m_mask = m;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Asserted at a negedge. Outputs are checked 1ns later, which confirms
  // the reset is asynchronous. Released at the following negedge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk_in);
    @(negedge clk_in);
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    rstn = 1'b1;
    hip_rx_valid = 0; hip_rx_sop = 0; hip_rx_eop = 0; hip_rx_err = 0;
    hip_rx_data = '0; hip_rx_be = '0; hip_rx_bardec = '0;
    app_rx_ready = 0; app_rx_mask = 0;
    model_reset();
    @(negedge clk_in);
    do_reset();

    // 3-beat TLP streamed straight through
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);

    // App stalls: HIP sends while ready, then RL more beats after ready drops
    n = 0;
    while (hip_rx_ready && n < 20) begin
      step(1, 1, 1, 0, 0);
      n++;
    end
    chk("ready_drop_bound", 128'(n < 20), 128'(1));
    repeat (RL) step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("no_overflow_with_rl", 128'(overflow), 128'(0));
    repeat (D + 2) step(0, 0, 0, 1, 0);

    // Overflow: 9 pushes without pops, then more while full
    repeat (D + 1) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    // Full with push and pop in the same cycle
    repeat (4) step(1, 1, 1, 1, 1);
    repeat (D + 2) step(0, 0, 0, 1, 0);

    // Framing: sop, sop, eop -> error on the second sop
    do_reset();
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 1, 1, 1);
    // Mid-packet reset, with the mask high so that its reset is visible
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    do_reset();
    step(0, 0, 0, 1, 0);

    // Random traffic, with both error flags allowed to fire
    repeat (400) begin
      logic v, s, e;
      v = ($urandom_range(0, 9) < 6);
      s = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 2) == 0);
      step(v, s, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    do_reset();
    repeat (200) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    check_outs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
